branch_pred_ctrl: RTL and testbench
===================================

BRANCH_PRED_CTRL -- requirements
Module: branch_pred_ctrl

Interface
REQ-001 The block SHALL take parameter IDX_BITS, default 4, meaning table depth 2**IDX_BITS, direct-mapped by PC[IDX_BITS+1:2].
REQ-002 The block SHALL take parameter CTR_BITS, default 2, meaning saturating-counter width (legal 1..4).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high (clk, reset).
REQ-004 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- PCF  in  32  fetch PC
- StallD  in  1  hold decode-stage registers
- BranchD  in  1  decode holds beq
- JumpD  in  1  decode holds j
- EqualD  in  1  branch comparison result
- PCBranchD  in  32  resolved branch target
- PCPlus4D  in  32  fall-through of decode instruction
- PredTakenF  out  1  fetch predicts taken
- PredTargetF  out  32  predicted fetch target
- PCSrcD  out  2  decode redirect: 00 none, 01 PCBranchD, 10 PCPlus4D, 11 jump
- FlushD  out  1  clear IF/ID register
- BranchCnt  out  32  resolved branches
- MissCnt  out  32  mispredicts

Function
REQ-005 Each entry SHALL hold valid, tag PC[31:IDX_BITS+2], 32-bit target and a CTR_BITS counter.
REQ-006 PredTakenF SHALL be combinational from PCF: valid & tag match & counter MSB=1.
REQ-007 PredTargetF SHALL be the entry target when PredTakenF=1, else 32'h0.
REQ-008 On each clk edge with StallD=0, PredTakenF, PredTargetF and the index/tag SHALL register into the D stage; with StallD=1 they SHALL hold.
REQ-009 When FlushD=1 and StallD=0, the D-stage registers SHALL load zeros (PredTakenD=0) instead.
REQ-010 When JumpD=1, PCSrcD SHALL be 11 and FlushD SHALL be 1; the table SHALL not be updated.
REQ-011 When BranchD=1, actual taken SHALL be EqualD.
REQ-012 Mispredict, PredTakenD=0 and taken: PCSrcD=01.
REQ-013 Mispredict, PredTakenD=1 and not taken: PCSrcD=10.
REQ-014 Mispredict, PredTakenD=1, taken and PredTargetD != PCBranchD: PCSrcD=01.
REQ-015 On any mispredict, FlushD SHALL be 1; otherwise PCSrcD=00 and FlushD=0.
REQ-016 Outputs PCSrcD and FlushD SHALL be combinational in D, so redirect latency is zero cycles after resolution.
REQ-017 On a resolved branch with StallD=0, the entry SHALL update at the clk edge:
- counter increments if taken, decrements if not, saturating at 2**CTR_BITS-1 and 0;
- on a tag hit, the target is rewritten when taken;
- on a tag miss and taken, the entry is allocated (valid=1, tag, target) with counter = 2**(CTR_BITS-1);
- on a tag miss and not taken, there is no change.
REQ-018 With StallD=1, no table update or counter change SHALL occur, and the outputs SHALL still reflect the D-stage state.
REQ-019 A same-cycle lookup and update of one index SHALL return the pre-update contents (no bypass).
REQ-020 BranchD and JumpD both high SHALL be treated as a jump.

Reset
REQ-021 Reset SHALL clear all valid bits and set counters to 2**(CTR_BITS-1)-1 (weakly not-taken), targets and tags to 0.
REQ-022 Reset SHALL clear D-stage registers and BranchCnt/MissCnt to 0.
REQ-023 Reset asserted mid-operation SHALL take effect immediately; PredTakenF=0, PCSrcD=00 and FlushD=0 while it is held.

Configuration
REQ-024 The macro BPRED_STATS_EN SHALL control the statistics counters.
REQ-025 With BPRED_STATS_EN defined, BranchCnt SHALL increment per resolved branch and MissCnt per mispredict (only when StallD=0), both saturating at 32'hFFFF_FFFF.
REQ-026 With BPRED_STATS_EN undefined, BranchCnt and MissCnt SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-027 Package bpred_pkg SHALL hold:
- the pcsrc_t enum (PCSRC_NONE, PCSRC_BRANCH, PCSRC_PLUS4, PCSRC_JUMP);
- the bpred_entry_t struct;
- counter-init constant functions.
REQ-028 One sub-module, bpred_table, SHALL implement the entry array with async read and sync write; resolution logic SHALL stay in branch_pred_ctrl.

Verification
REQ-029 Reset, then PCF=0x40 -> PredTakenF=0 and PredTargetF=0.
REQ-030 Branch at 0x40 to 0x80, taken, cold -> PCSrcD=01, FlushD=1, entry allocated; next PCF=0x40 -> PredTakenF=1, PredTargetF=0x80.
REQ-031 Same branch predicted taken, EqualD=0 -> PCSrcD=10 and FlushD=1; the counter drops 2->1 and the next lookup predicts not-taken.
REQ-032 Three taken resolutions with CTR_BITS=2 -> counter saturates at 3; one not-taken -> 2, still predicts taken.
REQ-033 JumpD=1 with BranchD=1 -> PCSrcD=11, FlushD=1, table unchanged; StallD=1 with a mispredicting branch -> no update and MissCnt unchanged.
REQ-034 With BPRED_STATS_EN defined, 5 branches with 2 mispredicts -> BranchCnt=5 and MissCnt=2; with it undefined, both read 0.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types and counter-init helpers for the branch predictor.
package bpred_pkg;
  localparam int MAX_TAG_BITS = 30;
  localparam int MAX_CTR_BITS = 4;
  typedef enum logic [1:0] {
    PCSRC_NONE   = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_PLUS4  = 2'b10,
    PCSRC_JUMP   = 2'b11
  } pcsrc_t;
  // Fields sized for the widest legal configuration; unused high bits stay zero.
  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    logic [MAX_CTR_BITS-1:0] ctr;
  } bpred_entry_t;
  function automatic logic [MAX_CTR_BITS-1:0] ctr_reset(int cb);
    return MAX_CTR_BITS'((1 << (cb - 1)) - 1);
  endfunction
  function automatic logic [MAX_CTR_BITS-1:0] ctr_alloc(int cb);
    return MAX_CTR_BITS'(1 << (cb - 1));
  endfunction
  function automatic logic [MAX_CTR_BITS-1:0] ctr_max(int cb);
    return MAX_CTR_BITS'((1 << cb) - 1);
  endfunction
endpackage

// File: rtl/bpred_table.sv
// bpred_table: direct-mapped predictor entry array, two async read ports, one sync write.
module bpred_table
  import bpred_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_idx_f,
  input  logic [IDX_BITS-1:0] i_idx_d,
  input  logic                i_we,
  input  bpred_entry_t        i_wdata,
  output bpred_entry_t        o_ent_f,
  output bpred_entry_t        o_ent_d
);
  localparam int DEPTH = 2 ** IDX_BITS;
  bpred_entry_t r_mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: ctr_reset(CTR_BITS)};
    end else if (i_we) begin
      r_mem[i_idx_d] <= i_wdata;
    end
  assign o_ent_f = r_mem[i_idx_f];
  assign o_ent_d = r_mem[i_idx_d];
endmodule

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: fetch-stage BTB/counter predictor with decode-stage resolution.
// Statistics counters are built only when BPRED_STATS_EN is defined.
module branch_pred_ctrl
  import bpred_pkg::*;
#(
  parameter int IDX_BITS = 4,
  parameter int CTR_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        EqualD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCPlus4D,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  output logic [1:0]  PCSrcD,
  output logic        FlushD,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);
  localparam int TAG_BITS = 32 - IDX_BITS - 2;
  logic [IDX_BITS-1:0] w_idx_f, r_idx_d;
  logic [TAG_BITS-1:0] w_tag_f, r_tag_d;
  logic                r_pred_taken_d;
  logic [31:0]         r_pred_target_d;
  bpred_entry_t        w_ent_f, w_ent_d, w_wr_ent;
  logic                w_hit_d, w_resolve, w_miss, w_we, w_unused;
  pcsrc_t              w_pcsrc;
  assign w_idx_f = PCF[IDX_BITS+1:2];
  assign w_tag_f = PCF[31:IDX_BITS+2];
  assign w_unused = ^{PCF[1:0], PCPlus4D};
  bpred_table #(.IDX_BITS(IDX_BITS), .CTR_BITS(CTR_BITS)) u_table (
    .clk     (clk),
    .rst     (reset),
    .i_idx_f (w_idx_f),
    .i_idx_d (r_idx_d),
    .i_we    (w_we),
    .i_wdata (w_wr_ent),
    .o_ent_f (w_ent_f),
    .o_ent_d (w_ent_d)
  );
  // Counter MSB set is the same as counter >= half-scale.
  assign PredTakenF  = !reset && w_ent_f.valid && w_ent_f.tag == MAX_TAG_BITS'(w_tag_f)
                       && w_ent_f.ctr >= ctr_alloc(CTR_BITS);
  assign PredTargetF = PredTakenF ? w_ent_f.target : 32'h0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_pred_taken_d  <= 1'b0;
      r_pred_target_d <= '0;
      r_idx_d         <= '0;
      r_tag_d         <= '0;
    end else if (!StallD) begin
      r_pred_taken_d  <= FlushD ? 1'b0 : PredTakenF;
      r_pred_target_d <= FlushD ? '0 : PredTargetF;
      r_idx_d         <= FlushD ? '0 : w_idx_f;
      r_tag_d         <= FlushD ? '0 : w_tag_f;
    end
  assign w_miss = BranchD && !JumpD && (r_pred_taken_d != EqualD ||
                  (r_pred_taken_d && EqualD && r_pred_target_d != PCBranchD));
  assign w_pcsrc = reset ? PCSRC_NONE : JumpD ? PCSRC_JUMP : !w_miss ? PCSRC_NONE :
                   (r_pred_taken_d && !EqualD) ? PCSRC_PLUS4 : PCSRC_BRANCH;
  assign PCSrcD = w_pcsrc;
  assign FlushD = !reset && (JumpD || w_miss);
  assign w_resolve = BranchD && !JumpD && !StallD;
  assign w_hit_d   = w_ent_d.valid && w_ent_d.tag == MAX_TAG_BITS'(r_tag_d);
  // A not-taken branch that misses the table leaves the entry untouched.
  assign w_we      = w_resolve && (w_hit_d || EqualD);
  always_comb begin
    w_wr_ent = w_ent_d;
    if (w_hit_d) begin
      w_wr_ent.ctr = EqualD ? (w_ent_d.ctr == ctr_max(CTR_BITS) ? w_ent_d.ctr : w_ent_d.ctr + 1'b1)
                            : (w_ent_d.ctr == '0 ? w_ent_d.ctr : w_ent_d.ctr - 1'b1);
      w_wr_ent.target = EqualD ? PCBranchD : w_ent_d.target;
    end else begin
      w_wr_ent = '{valid: 1'b1, tag: MAX_TAG_BITS'(r_tag_d), target: PCBranchD,
                   ctr: ctr_alloc(CTR_BITS)};
    end
  end
`ifdef BPRED_STATS_EN
  logic [31:0] r_branch_cnt, r_miss_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_branch_cnt <= '0;
      r_miss_cnt   <= '0;
    end else if (w_resolve) begin
      r_branch_cnt <= &r_branch_cnt ? r_branch_cnt : r_branch_cnt + 32'd1;
      r_miss_cnt   <= (w_miss && !(&r_miss_cnt)) ? r_miss_cnt + 32'd1 : r_miss_cnt;
    end
  assign BranchCnt = r_branch_cnt;
  assign MissCnt   = r_miss_cnt;
`else
  assign BranchCnt = 32'h0;
  assign MissCnt   = 32'h0;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed vector table plus randomized run against a reference model.
module tb_branch_pred_ctrl;
  localparam int IDX = 4;
  localparam int CB = 2;
  localparam int DEPTH = 1 << IDX;
`ifdef BPRED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF = '0, PCBranchD = '0, PCPlus4D = '0;
  logic        StallD = 1'b0, BranchD = 1'b0, JumpD = 1'b0, EqualD = 1'b0;
  logic        PredTakenF, FlushD;
  logic [31:0] PredTargetF, BranchCnt, MissCnt;
  logic [1:0]  PCSrcD;
  always #5 clk = ~clk;
  branch_pred_ctrl dut (
    .clk(clk), .reset(reset), .PCF(PCF), .StallD(StallD), .BranchD(BranchD),
    .JumpD(JumpD), .EqualD(EqualD), .PCBranchD(PCBranchD), .PCPlus4D(PCPlus4D),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF), .PCSrcD(PCSrcD),
    .FlushD(FlushD), .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {
    logic [31:0] pcf;
    bit          stall, br, jmp, eq;
    logic [31:0] pcb;
    bit          e_pt;
    logic [31:0] e_tgt;
    logic [1:0]  e_src;
    bit          e_fl;
  } vec_t;
  vec_t vecs[20];
  bit          mv[DEPTH];
  logic [31:0] mtag[DEPTH], mtgt[DEPTH];
  int          mc[DEPTH];
  bit          dpt;
  logic [31:0] dtgt, dpc;
  longint      bcnt, mcnt;
  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[IDX+1:2]);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mv[i] = 0; mtag[i] = 0; mtgt[i] = 0; mc[i] = (1 << (CB - 1)) - 1;
    end
    dpt = 0; dtgt = 0; dpc = 0; bcnt = 0; mcnt = 0;
  endtask
  task automatic rand_cycle();
    int          i, j, src;
    bit          hit, pt, miss, fl;
    logic [31:0] pc, tgt;
    @(negedge clk);
    pc = (32'($urandom_range(1, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
    PCF = pc; PCPlus4D = pc + 4;
    StallD = ($urandom_range(0, 4) == 0);
    BranchD = $urandom_range(0, 1);
    JumpD = ($urandom_range(0, 7) == 0);
    EqualD = $urandom_range(0, 1);
    case ($urandom_range(0, 2))
      0: PCBranchD = 32'h80;
      1: PCBranchD = 32'hC0;
      default: PCBranchD = 32'h100;
    endcase
    #1;
    i = idx_of(pc);
    hit = mv[i] && mtag[i] == tag_of(pc);
    pt = hit && mc[i] >= (1 << (CB - 1));
    tgt = pt ? mtgt[i] : 32'h0;
    miss = BranchD && !JumpD && ((dpt != EqualD) || (dpt && EqualD && dtgt != PCBranchD));
    src = JumpD ? 3 : !miss ? 0 : (dpt && !EqualD) ? 2 : 1;
    fl = JumpD || miss;
    chk("rnd_pred_taken", 32'(PredTakenF), 32'(pt));
    chk("rnd_pred_target", PredTargetF, tgt);
    chk("rnd_pcsrc", 32'(PCSrcD), 32'(src));
    chk("rnd_flush", 32'(FlushD), 32'(fl));
    chk("rnd_branch_cnt", BranchCnt, STATS ? 32'(bcnt) : 32'h0);
    chk("rnd_miss_cnt", MissCnt, STATS ? 32'(mcnt) : 32'h0);
    if (!StallD) begin
      if (BranchD && !JumpD) begin
        bcnt++;
        if (miss) mcnt++;
        j = idx_of(dpc);
        if (mv[j] && mtag[j] == tag_of(dpc)) begin
          mc[j] = EqualD ? ((mc[j] + 1 > (1 << CB) - 1) ? (1 << CB) - 1 : mc[j] + 1)
                         : ((mc[j] - 1 < 0) ? 0 : mc[j] - 1);
          if (EqualD) mtgt[j] = PCBranchD;
        end else if (EqualD) begin
          mv[j] = 1; mtag[j] = tag_of(dpc); mtgt[j] = PCBranchD; mc[j] = 1 << (CB - 1);
        end
      end
      dpt = fl ? 0 : pt;
      dtgt = fl ? 32'h0 : tgt;
      dpc = fl ? 32'h0 : pc;
    end
  endtask
  initial begin
    vecs[0]  = '{32'h40, 0, 0, 0, 0, 32'h0,  0, 32'h0,  2'd0, 0};
    vecs[1]  = '{32'h44, 0, 1, 0, 1, 32'h80, 0, 32'h0,  2'd1, 1};
    vecs[2]  = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[3]  = '{32'h80, 0, 1, 0, 0, 32'h80, 0, 32'h0,  2'd2, 1};
    vecs[4]  = '{32'h40, 0, 0, 0, 0, 32'h0,  0, 32'h0,  2'd0, 0};
    vecs[5]  = '{32'h44, 0, 1, 0, 1, 32'h80, 0, 32'h0,  2'd1, 1};
    vecs[6]  = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[7]  = '{32'h80, 0, 1, 0, 1, 32'h80, 0, 32'h0,  2'd0, 0};
    vecs[8]  = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[9]  = '{32'h80, 0, 1, 0, 1, 32'h80, 0, 32'h0,  2'd0, 0};
    vecs[10] = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[11] = '{32'h80, 0, 1, 0, 0, 32'h80, 0, 32'h0,  2'd2, 1};
    vecs[12] = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[13] = '{32'h80, 0, 1, 1, 0, 32'h80, 0, 32'h0,  2'd3, 1};
    vecs[14] = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[15] = '{32'h80, 1, 1, 0, 0, 32'h80, 0, 32'h0,  2'd2, 1};
    vecs[16] = '{32'h80, 0, 0, 0, 0, 32'h0,  0, 32'h0,  2'd0, 0};
    vecs[17] = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'h80, 2'd0, 0};
    vecs[18] = '{32'h80, 0, 1, 0, 1, 32'hC0, 0, 32'h0,  2'd1, 1};
    vecs[19] = '{32'h40, 0, 0, 0, 0, 32'h0,  1, 32'hC0, 2'd0, 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (vecs[k]) begin
      @(negedge clk);
      PCF = vecs[k].pcf; PCPlus4D = vecs[k].pcf + 4; StallD = vecs[k].stall;
      BranchD = vecs[k].br; JumpD = vecs[k].jmp; EqualD = vecs[k].eq; PCBranchD = vecs[k].pcb;
      #1;
      chk($sformatf("vec%0d_pred_taken", k), 32'(PredTakenF), 32'(vecs[k].e_pt));
      chk($sformatf("vec%0d_pred_target", k), PredTargetF, vecs[k].e_tgt);
      chk($sformatf("vec%0d_pcsrc", k), 32'(PCSrcD), 32'(vecs[k].e_src));
      chk($sformatf("vec%0d_flush", k), 32'(FlushD), 32'(vecs[k].e_fl));
    end
    @(negedge clk);
    PCF = 32'h40; StallD = 0; BranchD = 0; JumpD = 0; EqualD = 0; PCBranchD = 0;
    #1;
    chk("dir_branch_cnt", BranchCnt, STATS ? 32'd7 : 32'd0);
    chk("dir_miss_cnt", MissCnt, STATS ? 32'd5 : 32'd0);
    @(negedge clk);
    BranchD = 1; EqualD = 1; PCBranchD = 32'h100;
    #1;
    chk("pre_reset_pcsrc", 32'(PCSrcD), 32'd1);
    chk("pre_reset_pred_taken", 32'(PredTakenF), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("in_reset_pred_taken", 32'(PredTakenF), 32'd0);
    chk("in_reset_pcsrc", 32'(PCSrcD), 32'd0);
    chk("in_reset_flush", 32'(FlushD), 32'd0);
    chk("in_reset_branch_cnt", BranchCnt, 32'd0);
    chk("in_reset_miss_cnt", MissCnt, 32'd0);
    @(negedge clk);
    chk("held_reset_pcsrc", 32'(PCSrcD), 32'd0);
    reset = 1'b0; BranchD = 0; EqualD = 0;
    #1;
    chk("post_reset_pred_taken", 32'(PredTakenF), 32'd0);
    chk("post_reset_pred_target", PredTargetF, 32'd0);
    model_reset();
    for (int n = 0; n < 600; n++) rand_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
